pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Control-side driver for the PC datapath. Steps a 3-bit instruction address through a fixed program window and issues one-cycle RegWrite/MemWrite strobes decoded from per-address masks. Supports start/stall/done handshakes and counts retired instructions. Sits upstream of the PC datapath and drives its instruction_A, RegWrite and MemWrite inputs.

Parameters:
FIRST_ADDR, 3'd1, first instruction address issued after start.
LAST_ADDR, 3'd4, last instruction address issued (inclusive). Must satisfy LAST_ADDR >= FIRST_ADDR.
REG_WRITE_MASK, 8'b0000_0010, bit i set means address i asserts RegWrite.
MEM_WRITE_MASK, 8'b0000_0100, bit i set means address i asserts MemWrite.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low.
start  input  1  request to run the program; sampled only in IDLE.
stall  input  1  hold the current instruction; no strobes while high.
instruction_A  output  3  instruction address to the datapath.
RegWrite  output  1  register-file write strobe.
MemWrite  output  1  data-memory write strobe.
busy  output  1  high in RUN and HOLD.
done  output  1  one-cycle pulse on program completion.
retired  output  8  count of retired instructions, saturating.

Behaviour:
- Reset is asynchronous and active-low. While rst=0, all state clears immediately: state=IDLE, instruction_A=0, RegWrite=0, MemWrite=0, busy=0, done=0, retired=0. Reset mid-run abandons the program; no strobe is issued after rst deasserts until a new start.
- All outputs are registered and change only on the rising edge of clk (except the asynchronous clear).
- States:
  - IDLE: outputs are 0, except instruction_A, which holds its last value. If start=1, go to RUN: instruction_A<=FIRST_ADDR, busy<=1, and strobes are loaded from the masks at FIRST_ADDR.
  - RUN: the current address is presented with its strobes for exactly this cycle.
    - stall=0 and instruction_A!=LAST_ADDR: instruction_A<=instruction_A+1, strobes loaded from the masks at the new address, retired++.
    - stall=0 and instruction_A==LAST_ADDR: go to DONE, retired++, strobes<=0, busy<=0, done<=1.
    - stall=1: go to HOLD with the address unchanged and strobes<=0.
  - HOLD: the address is held and strobes stay 0.
    - stall=1: remain in HOLD.
    - stall=0 and instruction_A!=LAST_ADDR: advance to the next address with its strobes, retired++, return to RUN.
    - stall=0 and instruction_A==LAST_ADDR: go to DONE as in RUN.
  - DONE: done is high for this single cycle. Next state is IDLE with done<=0. A start in this cycle is ignored.
- Strobe rules:
  - Each address's strobes are high for exactly one cycle per run, in the first cycle that address is presented. A stall never repeats a write.
  - RegWrite and MemWrite may both be high if both mask bits are set.
  - A mask bit that is 0 yields no strobe.
- Latency: with no stalls, start at edge N gives FIRST_ADDR at N+1. The run takes (LAST_ADDR-FIRST_ADDR+1) cycles in RUN, then done is high for one cycle.
- Handshake: start is ignored while busy=1 or done=1. A stall asserted in IDLE or DONE has no effect.
- Address width: instruction_A never wraps, because LAST_ADDR<=7 bounds it.
- retired saturates at 255 and persists across runs; it clears only on reset.
- Simultaneous events:
  - stall=1 in the same cycle as the LAST_ADDR completion edge: the stall wins. Go to HOLD; completion waits until stall=0.
  - start and stall both high in IDLE: start is taken. The stall is first evaluated in the following RUN cycle.

Test Plan:
- Reset then single run: rst low for 5 ns, start one cycle. Required addresses 1,2,3,4 on consecutive cycles. RegWrite=1 only at address 1. MemWrite=1 only at address 2. done pulses one cycle after address 4. retired=4, busy=0 afterward.
- Stall during a write: stall=1 for 3 cycles while address 2 is presented. Required: MemWrite high exactly one cycle, address 2 held 4 cycles total, retired=4 at end, done once.
- Stall at the last address: stall=1 while address 4 is presented. Required: done is not asserted until the cycle after stall drops; address held at 4.
- Start while busy: a second start pulse at address 3. Required: ignored; exactly one done, retired=4. A start after done restarts at address 1 and gives retired=8.
- Asynchronous reset mid-run: rst=0 between clock edges at address 2. Required: instruction_A, strobes, busy and retired all 0 immediately, with no clock edge needed. After release, the block stays idle with no strobes until start.
- Mask override: FIRST=0, LAST=7, REG_WRITE_MASK=8'hFF, MEM_WRITE_MASK=8'h81. Required: RegWrite high for 8 cycles, MemWrite at addresses 0 and 7 only, no wrap past 7, retired=8.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Control-side driver for the PC datapath. After a start request it steps
//   instruction_A from FIRST_ADDR to LAST_ADDR (inclusive). In the first cycle
//   each address is presented, it issues one-cycle RegWrite/MemWrite strobes
//   decoded from per-address masks. A stall holds the current address without
//   repeating its strobes. A one-cycle done pulse marks completion, and a
//   saturating counter records retired instructions.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   start          run request, sampled only while idle
//   stall          hold the current instruction, suppressing strobes
//   instruction_A  instruction address to the datapath
//   RegWrite       register-file write strobe
//   MemWrite       data-memory write strobe
//   busy           high while running or holding
//   done           one-cycle completion pulse
//   retired        retired-instruction count, saturating at 255
module pc_sequencer #(
    parameter logic [2:0] FIRST_ADDR     = 3'd1,
    parameter logic [2:0] LAST_ADDR      = 3'd4,
    parameter logic [7:0] REG_WRITE_MASK = 8'b0000_0010,
    parameter logic [7:0] MEM_WRITE_MASK = 8'b0000_0100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic [2:0] instruction_A,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       busy,
    output logic       done,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t     state;
    logic [2:0] next_addr;
    logic       at_last;
    logic [7:0] retired_inc;

    // next_addr cannot wrap: it is only used when instruction_A != LAST_ADDR <= 7.
    always_comb begin
        next_addr   = instruction_A + 3'd1;
        at_last     = (instruction_A == LAST_ADDR);
        retired_inc = (retired == 8'hFF) ? retired : retired + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            instruction_A <= '0;
            RegWrite      <= 1'b0;
            MemWrite      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            retired       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    RegWrite <= 1'b0;
                    MemWrite <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        state         <= S_RUN;
                        instruction_A <= FIRST_ADDR;
                        RegWrite      <= REG_WRITE_MASK[FIRST_ADDR];
                        MemWrite      <= MEM_WRITE_MASK[FIRST_ADDR];
                        busy          <= 1'b1;
                    end
                end

                // RUN and HOLD share their exits. Only entry into a new address
                // loads strobes, so a stall can never repeat a write.
                S_RUN, S_HOLD: begin
                    if (stall) begin
                        state    <= S_HOLD;
                        RegWrite <= 1'b0;
                        MemWrite <= 1'b0;
                    end else if (!at_last) begin
                        state         <= S_RUN;
                        instruction_A <= next_addr;
                        RegWrite      <= REG_WRITE_MASK[next_addr];
                        MemWrite      <= MEM_WRITE_MASK[next_addr];
                        retired       <= retired_inc;
                    end else begin
                        state    <= S_DONE;
                        RegWrite <= 1'b0;
                        MemWrite <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        retired  <= retired_inc;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    RegWrite <= 1'b0;
                    MemWrite <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    typedef struct packed {
        logic [2:0] a;
        logic       rw;
        logic       mw;
        logic       busy;
        logic       done;
        logic [7:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       stall = 1'b0;

    logic [2:0] a1, a2;
    logic       rw1, mw1, busy1, done1;
    logic       rw2, mw2, busy2, done2;
    logic [7:0] ret1, ret2;

    exp_t q1[$];
    exp_t q2[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    pc_sequencer u1 (
        .clk(clk), .rst(rst), .start(start1), .stall(stall),
        .instruction_A(a1), .RegWrite(rw1), .MemWrite(mw1),
        .busy(busy1), .done(done1), .retired(ret1)
    );

    pc_sequencer #(
        .FIRST_ADDR(3'd0),
        .LAST_ADDR(3'd7),
        .REG_WRITE_MASK(8'hFF),
        .MEM_WRITE_MASK(8'h81)
    ) u2 (
        .clk(clk), .rst(rst), .start(start2), .stall(stall),
        .instruction_A(a2), .RegWrite(rw2), .MemWrite(mw2),
        .busy(busy2), .done(done2), .retired(ret2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push1(input int a, input int rw, input int mw, input int b, input int d, input int r);
        q1.push_back('{a[2:0], rw[0], mw[0], b[0], d[0], r[7:0]});
    endtask

    task automatic push2(input int a, input int rw, input int mw, input int b, input int d, input int r);
        q2.push_back('{a[2:0], rw[0], mw[0], b[0], d[0], r[7:0]});
    endtask

    // Monitors: whenever a DUT is busy or pulsing done, pop and compare;
    // otherwise it must emit no strobes.
    always @(posedge clk) begin
        exp_t e, g;
        #1;
        g = '{a1, rw1, mw1, busy1, done1, ret1};
        if (busy1 || done1) begin
            compared++;
            if (q1.size() == 0) begin
                mismatched++;
                $display("FAIL u1_unexpected: got a=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d, required no activity",
                         g.a, g.rw, g.mw, g.busy, g.done, g.ret);
            end else begin
                e = q1.pop_front();
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL u1_cycle: got a=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d, required a=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d",
                             g.a, g.rw, g.mw, g.busy, g.done, g.ret, e.a, e.rw, e.mw, e.busy, e.done, e.ret);
                end
            end
        end else begin
            chk("u1_idle_strobes", {30'd0, rw1, mw1}, 32'd0);
        end
    end

    always @(posedge clk) begin
        exp_t e, g;
        #1;
        g = '{a2, rw2, mw2, busy2, done2, ret2};
        if (busy2 || done2) begin
            compared++;
            if (q2.size() == 0) begin
                mismatched++;
                $display("FAIL u2_unexpected: got a=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d, required no activity",
                         g.a, g.rw, g.mw, g.busy, g.done, g.ret);
            end else begin
                e = q2.pop_front();
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL u2_cycle: got a=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d, required a=%0d rw=%0b mw=%0b busy=%0b done=%0b ret=%0d",
                             g.a, g.rw, g.mw, g.busy, g.done, g.ret, e.a, e.rw, e.mw, e.busy, e.done, e.ret);
                end
            end
        end else begin
            chk("u2_idle_strobes", {30'd0, rw2, mw2}, 32'd0);
        end
    end

    // Asserts reset between edges and checks the clear happens without a clock.
    task automatic do_reset(input string name);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk({name, "_u1_clear"}, {18'd0, a1, rw1, mw1, busy1, done1, ret1}, 32'd0);
        chk({name, "_u2_clear"}, {18'd0, a2, rw2, mw2, busy2, done2, ret2}, 32'd0);
        #4 rst = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge where FIRST_ADDR is being presented.
    task automatic start_pulse(input bit sel2, input logic with_stall);
        @(negedge clk);
        if (sel2) start2 = 1'b1;
        else      start1 = 1'b1;
        stall = with_stall;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        stall  = 1'b0;
    endtask

    task automatic push_plain_run(input int base);
        push1(1, 1, 0, 1, 0, base);
        push1(2, 0, 1, 1, 0, base + 1);
        push1(3, 0, 0, 1, 0, base + 2);
        push1(4, 0, 0, 1, 0, base + 3);
        push1(4, 0, 0, 0, 1, base + 4);
    endtask

    initial begin
        // Reset then a single run
        do_reset("t1");
        push_plain_run(0);
        start_pulse(1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("t1_retired", {24'd0, ret1}, 32'd4);
        chk("t1_busy", {31'd0, busy1}, 32'd0);
        chk("t1_drained", q1.size(), 32'd0);

        // Stall for three cycles while address 2 (MemWrite) is presented
        do_reset("t2");
        push1(1, 1, 0, 1, 0, 0);
        push1(2, 0, 1, 1, 0, 1);
        push1(2, 0, 0, 1, 0, 1);
        push1(2, 0, 0, 1, 0, 1);
        push1(2, 0, 0, 1, 0, 1);
        push1(3, 0, 0, 1, 0, 2);
        push1(4, 0, 0, 1, 0, 3);
        push1(4, 0, 0, 0, 1, 4);
        start_pulse(1'b0, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_retired", {24'd0, ret1}, 32'd4);
        chk("t2_drained", q1.size(), 32'd0);

        // Stall at the last address delays done
        do_reset("t3");
        push1(1, 1, 0, 1, 0, 0);
        push1(2, 0, 1, 1, 0, 1);
        push1(3, 0, 0, 1, 0, 2);
        push1(4, 0, 0, 1, 0, 3);
        push1(4, 0, 0, 1, 0, 3);
        push1(4, 0, 0, 1, 0, 3);
        push1(4, 0, 0, 0, 1, 4);
        start_pulse(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_retired", {24'd0, ret1}, 32'd4);
        chk("t3_drained", q1.size(), 32'd0);

        // Start while busy is ignored; restart after done accumulates retired
        do_reset("t4");
        push_plain_run(0);
        start_pulse(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_retired_first", {24'd0, ret1}, 32'd4);
        push_plain_run(4);
        start_pulse(1'b0, 1'b1);   // stall alongside start in idle has no effect
        repeat (6) @(negedge clk);
        chk("t4_retired_second", {24'd0, ret1}, 32'd8);
        chk("t4_drained", q1.size(), 32'd0);

        // Asynchronous reset mid-run at address 2
        do_reset("t5pre");
        push1(1, 1, 0, 1, 0, 0);
        push1(2, 0, 1, 1, 0, 1);
        start_pulse(1'b0, 1'b0);
        do_reset("t5");
        repeat (5) @(negedge clk);
        chk("t5_idle_addr", {29'd0, a1}, 32'd0);
        chk("t5_idle_busy", {31'd0, busy1}, 32'd0);
        chk("t5_drained", q1.size(), 32'd0);

        // Mask override instance: full window 0..7
        do_reset("t6");
        for (int unsigned i = 0; i < 8; i++)
            push2(int'(i), 1, (i == 0 || i == 7) ? 1 : 0, 1, 0, int'(i));
        push2(7, 0, 0, 0, 1, 8);
        start_pulse(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6_retired", {24'd0, ret2}, 32'd8);
        chk("t6_addr_no_wrap", {29'd0, a2}, 32'd7);
        chk("t6_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
